// File: rtl/flash_cmd_axil_master.sv
// Command FIFO feeding a single-outstanding AXI4-Lite master for the flash wrapper.
// The operation is encoded in AxADDR[26:24]; each result comes back on a valid/ready response port.
module flash_cmd_axil_master #(
   parameter int CMD_DEPTH = 4,
   parameter int ADDR_W    = 24
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [1:0]        rsp_op,
   output logic [31:0]       M_AWADDR,
   output logic              M_AWVALID,
   output logic [2:0]        M_AWPROT,
   input  logic              M_AWREADY,
   output logic [31:0]       M_WDATA,
   output logic [3:0]        M_WSTRB,
   output logic              M_WVALID,
   input  logic              M_WREADY,
   input  logic              M_BVALID,
   input  logic [1:0]        M_BRESP,
   output logic              M_BREADY,
   output logic [31:0]       M_ARADDR,
   output logic              M_ARVALID,
   output logic [2:0]        M_ARPROT,
   input  logic              M_ARREADY,
   input  logic              M_RVALID,
   input  logic [31:0]       M_RDATA,
   input  logic [1:0]        M_RRESP,
   output logic              M_RREADY
);

   localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int CNT_W = $clog2(CMD_DEPTH + 1);
   localparam int ENT_W = 2 + ADDR_W + 32;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);

   localparam logic [1:0] OP_READ   = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_ERASE_SECTOR = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_RESP,
      S_RD_REQ,
      S_RD_DATA,
      S_RSP
   } state_t;

   state_t state_q, state_d;

   logic [ENT_W-1:0] mem_q [CMD_DEPTH];
   logic [ENT_W-1:0] mem_d [CMD_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              push, pop;
   logic [ENT_W-1:0]  head;
   logic [1:0]        head_op;
   logic [2:0]        op_bits;
   logic [31:0]       ax_addr;
   logic              aw_fin, w_fin;

   assign cmd_ready = (count_q != FULL_CNT);
   assign push      = cmd_valid & cmd_ready;
   assign pop       = (state_q == S_IDLE) && (count_q != '0);
   assign head      = mem_q[rd_ptr_q];
   assign head_op   = head[ENT_W-1 -: 2];

   // One-hot operation field in [26:24]; reads and writes share the plain-access bit.
   always_comb begin
      op_bits = 3'b001;
      case (op_q)
         OP_ERASE_SECTOR: op_bits = 3'b010;
         2'b11:           op_bits = 3'b100;
         default:         op_bits = 3'b001;
      endcase
   end

   assign ax_addr   = {5'b00000, op_bits, 24'(addr_q)};

   assign M_AWADDR  = ax_addr;
   assign M_ARADDR  = ax_addr;
   assign M_AWPROT  = 3'b000;
   assign M_ARPROT  = 3'b000;
   assign M_WSTRB   = 4'hF;
   assign M_WDATA   = wdata_q;
   assign M_AWVALID = (state_q == S_WR_REQ) && !aw_done_q;
   assign M_WVALID  = (state_q == S_WR_REQ) && !w_done_q;
   assign M_BREADY  = (state_q == S_WR_RESP);
   assign M_ARVALID = (state_q == S_RD_REQ);
   assign M_RREADY  = (state_q == S_RD_DATA);
   assign rsp_valid = (state_q == S_RSP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign rsp_op    = op_q;

   assign aw_fin = aw_done_q | (M_AWVALID & M_AWREADY);
   assign w_fin  = w_done_q  | (M_WVALID  & M_WREADY);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {cmd_op, cmd_addr, cmd_wdata};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Transaction sequencer: each popped command runs to its response handshake before the next pop.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               op_d      = head_op;
               addr_d    = head[32 +: ADDR_W];
               wdata_d   = (head_op == OP_WRITE) ? head[31:0] : 32'h0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = (head_op == OP_READ) ? S_RD_REQ : S_WR_REQ;
            end
         end
         S_WR_REQ: begin
            if (aw_fin && w_fin) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = S_WR_RESP;
            end else begin
               aw_done_d = aw_fin;
               w_done_d  = w_fin;
            end
         end
         S_WR_RESP: begin
            if (M_BVALID) begin
               err_d   = |M_BRESP;
               rdata_d = 32'h0;
               state_d = S_RSP;
            end
         end
         S_RD_REQ: begin
            if (M_ARREADY) begin
               state_d = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (M_RVALID) begin
               err_d   = |M_RRESP;
               rdata_d = M_RDATA;
               state_d = S_RSP;
            end
         end
         S_RSP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Entry storage carries no reset; the pointers and count alone define what is queued.
   always_ff @(posedge ACLK) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         op_q      <= 2'b00;
         addr_q    <= '0;
         wdata_q   <= 32'h0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= 32'h0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_flash_cmd_axil_master.sv
// Randomized bench for flash_cmd_axil_master: random producer, AXI4-Lite slave and response consumer,
// checked every cycle against a queue-based model of the command flow.
module tb_flash_cmd_axil_master;

   localparam int DEPTH  = 4;
   localparam int CYCLES = 6000;

   logic        ACLK;
   logic        ARESET;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [23:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [1:0]  rsp_op;
   logic [31:0] M_AWADDR;
   logic        M_AWVALID;
   logic [2:0]  M_AWPROT;
   logic        M_AWREADY;
   logic [31:0] M_WDATA;
   logic [3:0]  M_WSTRB;
   logic        M_WVALID;
   logic        M_WREADY;
   logic        M_BVALID;
   logic [1:0]  M_BRESP;
   logic        M_BREADY;
   logic [31:0] M_ARADDR;
   logic        M_ARVALID;
   logic [2:0]  M_ARPROT;
   logic        M_ARREADY;
   logic        M_RVALID;
   logic [31:0] M_RDATA;
   logic [1:0]  M_RRESP;
   logic        M_RREADY;

   flash_cmd_axil_master #(.CMD_DEPTH(DEPTH), .ADDR_W(24)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_op(rsp_op),
      .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWPROT(M_AWPROT), .M_AWREADY(M_AWREADY),
      .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
      .M_BVALID(M_BVALID), .M_BRESP(M_BRESP), .M_BREADY(M_BREADY),
      .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARPROT(M_ARPROT), .M_ARREADY(M_ARREADY),
      .M_RVALID(M_RVALID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RREADY(M_RREADY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   typedef struct packed {
      logic [1:0]  op;
      logic [23:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   int tests  = 0;
   int errors = 0;

   // Reference model: queued commands, the one in flight, and which handshake each channel still owes.
   cmd_t        fifo_q[$];
   cmd_t        cur;
   bit          busy, aw_pend, w_pend, b_pend, ar_pend, r_pend, rsp_pend;
   logic [31:0] exp_rdata;
   logic        exp_err;
   bit          just_reset;
   int          completed;
   bit          did_rd_reset;

   // Slave and producer bookkeeping.
   bit          s_aw_got, s_w_got, s_b_armed, s_r_armed;
   int          s_b_delay, s_r_delay;
   logic [1:0]  s_bresp, s_rresp;
   logic [31:0] s_rdata;
   bit          prod_pend;
   cmd_t        prod;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc_addr(input cmd_t c);
      case (c.op)
         2'd0, 2'd1: return {8'h01, c.addr};
         2'd2:       return {8'h02, c.addr};
         default:    return {8'h04, c.addr};
      endcase
   endfunction

   function automatic logic [1:0] rand_resp();
      if ($urandom_range(0, 99) < 15) return 2'($urandom_range(1, 3));
      return 2'b00;
   endfunction

   task automatic check_cycle();
      checkOutput("cmd_ready", cmd_ready, fifo_q.size() < DEPTH);
      checkOutput("awvalid", M_AWVALID, aw_pend);
      checkOutput("wvalid", M_WVALID, w_pend);
      checkOutput("bready", M_BREADY, b_pend);
      checkOutput("arvalid", M_ARVALID, ar_pend);
      checkOutput("rready", M_RREADY, r_pend);
      checkOutput("rsp_valid", rsp_valid, rsp_pend);
      if (aw_pend) begin
         checkOutput("awaddr", M_AWADDR, enc_addr(cur));
         checkOutput("awprot", M_AWPROT, 3'b000);
      end
      if (w_pend) begin
         checkOutput("wdata", M_WDATA, (cur.op == 2'd1) ? cur.wdata : 32'h0);
         checkOutput("wstrb", M_WSTRB, 4'hF);
      end
      if (ar_pend) begin
         checkOutput("araddr", M_ARADDR, enc_addr(cur));
         checkOutput("arprot", M_ARPROT, 3'b000);
      end
      if (rsp_pend) begin
         checkOutput("rsp_op", rsp_op, cur.op);
         checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
         checkOutput("rsp_err", rsp_err, exp_err);
      end
      if (just_reset) begin
         checkOutput("rst_rdata", rsp_rdata, 32'h0);
         checkOutput("rst_err", rsp_err, 1'b0);
         checkOutput("rst_op", rsp_op, 2'b00);
      end
   endtask

   task automatic applyStimulus(input int cyc);
      ARESET = (cyc < 3);
      if (cyc >= 3 && !did_rd_reset && r_pend && fifo_q.size() >= 2) begin
         ARESET       = 1'b1;
         did_rd_reset = 1'b1;
      end else if (cyc >= 3 && $urandom_range(0, 999) < 2) begin
         ARESET = 1'b1;
      end
      if (!prod_pend && $urandom_range(0, 99) < 60) begin
         prod_pend  = 1'b1;
         prod.op    = 2'($urandom_range(0, 3));
         prod.addr  = 24'($urandom);
         prod.wdata = $urandom;
      end
      cmd_valid = prod_pend;
      cmd_op    = prod.op;
      cmd_addr  = prod.addr;
      cmd_wdata = prod.wdata;
      if (((cyc / 150) % 2) == 1) rsp_ready = ($urandom_range(0, 9) == 0);
      else                        rsp_ready = ($urandom_range(0, 9) < 6);
      M_AWREADY = ($urandom_range(0, 2) != 0);
      M_WREADY  = ($urandom_range(0, 2) != 0);
      M_ARREADY = ($urandom_range(0, 2) != 0);
      if (!s_b_armed) begin
         M_BVALID = 1'b0;
         M_BRESP  = 2'($urandom);
      end else if (!M_BVALID) begin
         if (s_b_delay == 0) begin
            M_BVALID = 1'b1;
            M_BRESP  = s_bresp;
         end else begin
            s_b_delay--;
         end
      end
      if (!s_r_armed) begin
         M_RVALID = 1'b0;
         M_RDATA  = $urandom;
         M_RRESP  = 2'($urandom);
      end else if (!M_RVALID) begin
         if (s_r_delay == 0) begin
            M_RVALID = 1'b1;
            M_RDATA  = s_rdata;
            M_RRESP  = s_rresp;
         end else begin
            s_r_delay--;
         end
      end
   endtask

   task automatic advance_model();
      bit pop_now, had_wr;
      if (ARESET) begin
         fifo_q.delete();
         busy = 0; aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0; rsp_pend = 0;
         s_aw_got = 0; s_w_got = 0; s_b_armed = 0; s_r_armed = 0;
         prod_pend  = 0;
         just_reset = 1;
         return;
      end
      just_reset = 0;
      pop_now = !busy && (fifo_q.size() > 0);
      if (rsp_pend && rsp_ready) begin
         rsp_pend = 0;
         busy     = 0;
         completed++;
      end
      if (b_pend && M_BVALID) begin
         b_pend = 0; rsp_pend = 1; exp_err = |M_BRESP; exp_rdata = 32'h0;
      end
      if (r_pend && M_RVALID) begin
         r_pend = 0; rsp_pend = 1; exp_err = |M_RRESP; exp_rdata = M_RDATA;
      end
      if (ar_pend && M_ARREADY) begin
         ar_pend = 0; r_pend = 1;
      end
      had_wr = aw_pend || w_pend;
      if (aw_pend && M_AWREADY) aw_pend = 0;
      if (w_pend && M_WREADY) w_pend = 0;
      if (had_wr && !aw_pend && !w_pend) b_pend = 1;
      if (pop_now) begin
         cur  = fifo_q.pop_front();
         busy = 1;
         if (cur.op == 2'd0) ar_pend = 1;
         else begin
            aw_pend = 1; w_pend = 1;
         end
      end
      if (cmd_valid && (fifo_q.size() + (pop_now ? 1 : 0)) < DEPTH) fifo_q.push_back(prod);
      // Slave side follows the DUT's actual handshakes.
      if (M_AWVALID && M_AWREADY) s_aw_got = 1;
      if (M_WVALID && M_WREADY) s_w_got = 1;
      if (M_BVALID && M_BREADY) s_b_armed = 0;
      if (s_aw_got && s_w_got && !s_b_armed) begin
         s_b_armed = 1; s_b_delay = $urandom_range(0, 3); s_bresp = rand_resp();
         s_aw_got = 0; s_w_got = 0;
      end
      if (M_RVALID && M_RREADY) s_r_armed = 0;
      if (M_ARVALID && M_ARREADY) begin
         s_r_armed = 1; s_r_delay = $urandom_range(0, 4); s_rdata = $urandom; s_rresp = rand_resp();
      end
      if (cmd_valid && cmd_ready) prod_pend = 0;
   endtask

   initial begin
      ARESET = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 24'h0; cmd_wdata = 32'h0;
      rsp_ready = 1'b0; M_AWREADY = 1'b0; M_WREADY = 1'b0; M_ARREADY = 1'b0;
      M_BVALID = 1'b0; M_BRESP = 2'b00; M_RVALID = 1'b0; M_RDATA = 32'h0; M_RRESP = 2'b00;
      busy = 0; aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0; rsp_pend = 0;
      exp_rdata = 32'h0; exp_err = 1'b0; just_reset = 1; completed = 0; did_rd_reset = 0;
      s_aw_got = 0; s_w_got = 0; s_b_armed = 0; s_r_armed = 0; s_b_delay = 0; s_r_delay = 0;
      s_bresp = 2'b00; s_rresp = 2'b00; s_rdata = 32'h0; prod_pend = 0; prod = '0;
      for (int cyc = 0; cyc < CYCLES; cyc++) begin
         @(negedge ACLK);
         check_cycle();
         applyStimulus(cyc);
         advance_model();
      end
      checkOutput("rd_data_reset_seen", did_rd_reset, 1'b1);
      checkOutput("progress", completed > 100, 1'b1);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
